// File: rtl/cpu_strap_pkg.sv
// cpu_strap_pkg: shared strap bundle layout, state and ID encodings for the strap sampler
package cpu_strap_pkg;
  localparam int STRAP_W   = 14;
  localparam int SKT_LSB   = 0;
  localparam int PROC1_LSB = 2;
  localparam int PROC2_LSB = 4;
  localparam int PKG1_LSB  = 6;
  localparam int PKG2_LSB  = 9;
  localparam int INTR_LSB  = 12;
  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, LOCKED = 2'd2} state_e;
  typedef enum logic [1:0] {ICX = 2'b00, CPX = 2'b01, STP = 2'b11} proc_id_e;
  typedef enum logic [2:0] {NON_MCP = 3'b000, XCC_CPX4 = 3'b001, CPX6_CPU = 3'b010, STP_CPU = 3'b111} pkg_id_e;
  // Sockets read as not present (active low) until a snapshot is taken
  localparam logic [STRAP_W-1:0] STRAP_RST = 14'h0003;
endpackage

// File: rtl/strap_sync.sv
// strap_sync: WIDTH-bit multi-flop synchronizer chain for asynchronous strap pins
module strap_sync #(
  parameter int WIDTH       = 14,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  // Shift the raw bundle through the chain; the oldest stage is the synchronized view
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end
  assign q_o = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/cpu_strap_sampler.sv
// cpu_strap_sampler: synchronize, debounce and latch CPU strap pins; optional post-lock change monitor under CPU_STRAP_CHANGE_MON_EN
module cpu_strap_sampler
  import cpu_strap_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iAuxPwrDone,
  input  logic       iRearm,
  input  logic [1:0] invCPUSktOcc,
  input  logic [1:0] ivProcIDCPU1,
  input  logic [1:0] ivProcIDCPU2,
  input  logic [2:0] ivPkgIDCPU1,
  input  logic [2:0] ivPkgIDCPU2,
  input  logic [1:0] ivIntr,
  output logic [1:0] onvCPUSktOcc,
  output logic [1:0] ovProcIDCPU1,
  output logic [1:0] ovProcIDCPU2,
  output logic [2:0] ovPkgIDCPU1,
  output logic [2:0] ovPkgIDCPU2,
  output logic [1:0] ovIntr,
  output logic       oStrapValid,
  output logic       oStrapChanged
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [STRAP_W-1:0] raw, sync, prev_q, snap_q, snap_d;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic changed_q, changed_d, chg_set;
  assign raw = {ivIntr, ivPkgIDCPU2, ivPkgIDCPU1, ivProcIDCPU2, ivProcIDCPU1, invCPUSktOcc};
  strap_sync #(.WIDTH(STRAP_W), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (iClk),
    .rst_n_i(iRst_n),
    .d_i    (raw),
    .q_o    (sync)
  );
`ifdef CPU_STRAP_CHANGE_MON_EN
  logic [CW-1:0] mon_q, mon_d;
  // Count consecutive locked cycles where the pins disagree with the snapshot
  always_comb begin
    mon_d   = '0;
    chg_set = 1'b0;
    if (iAuxPwrDone && !iRearm && state_q == LOCKED && sync != snap_q) begin
      chg_set = (mon_q == CNT_MAX);
      mon_d   = chg_set ? mon_q : mon_q + 1'b1;
    end
  end
  // Drift counter register
  always_ff @(posedge iClk) begin
    if (!iRst_n) mon_q <= '0;
    else         mon_q <= mon_d;
  end
`else
  assign chg_set = 1'b0;
`endif
  // Next state: aux loss beats rearm, which beats the debounce/lock logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    snap_d    = snap_q;
    changed_d = changed_q;
    if (!iAuxPwrDone) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (iRearm) begin
      cnt_d     = '0;
      changed_d = 1'b0;
      state_d   = (state_q == LOCKED) ? SETTLE : state_q;
    end else begin
      case (state_q)
        IDLE: state_d = SETTLE;
        SETTLE: begin
          if (sync != prev_q) cnt_d = '0;
          else if (cnt_q == CNT_MAX) begin
            snap_d  = sync;
            state_d = LOCKED;
          end else cnt_d = cnt_q + 1'b1;
        end
        default: changed_d = changed_q | chg_set;
      endcase
    end
  end
  // State, counter, snapshot and previous-bundle registers
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prev_q    <= '0;
      snap_q    <= STRAP_RST;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prev_q    <= sync;
      snap_q    <= snap_d;
      changed_q <= changed_d;
    end
  end
  assign onvCPUSktOcc  = snap_q[SKT_LSB +: 2];
  assign ovProcIDCPU1  = snap_q[PROC1_LSB +: 2];
  assign ovProcIDCPU2  = snap_q[PROC2_LSB +: 2];
  assign ovPkgIDCPU1   = snap_q[PKG1_LSB +: 3];
  assign ovPkgIDCPU2   = snap_q[PKG2_LSB +: 3];
  assign ovIntr        = snap_q[INTR_LSB +: 2];
  assign oStrapValid   = (state_q == LOCKED);
  assign oStrapChanged = changed_q;
endmodule
